// File: rtl/principal_pkg.sv
// Shared constants and types for the score evaluator.
// Segment patterns are packed {a,b,c,d,e,f,g}, 1 = lit.
package principal_pkg;

    typedef enum logic [1:0] {
        FAIL  = 2'b00,
        RECOV = 2'b01,
        PASS  = 2'b10,
        EXCEL = 2'b11
    } class_e;

    typedef enum logic [1:0] {
        MODE_HEX   = 2'b00,
        MODE_CLASS = 2'b01,
        MODE_UNITS = 2'b10,
        MODE_TENS  = 2'b11
    } mode_e;

    localparam logic [3:0] THR_RECOV = 4'd5;
    localparam logic [3:0] THR_PASS  = 4'd10;
    localparam logic [3:0] THR_EXCEL = 4'd14;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [6:0] SEG_LF = 7'h47;
    localparam logic [6:0] SEG_LR = 7'h05;
    localparam logic [6:0] SEG_LA = 7'h77;
    localparam logic [6:0] SEG_LE = 7'h4F;

    function automatic class_e classify(
        input logic [3:0] s
    );
        if (s >= THR_EXCEL)
            return EXCEL;
        else if (s >= THR_PASS)
            return PASS;
        else if (s >= THR_RECOV)
            return RECOV;
        else
            return FAIL;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to seven-segment pattern.
// Ports: val (4-bit digit in), seg (7-bit {a..g} out).
module hex_to_7seg
    import principal_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[val];

endmodule

// File: rtl/principal.sv
// Registered score evaluator with seven-segment readout.
// Ports: clk, rst_n, e1..e0 mode, p3..p0 score,
// y1..y0 class code, seg_a..seg_g segment drives.
module principal
    import principal_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic e1,
    input  logic e0,
    input  logic p3,
    input  logic p2,
    input  logic p1,
    input  logic p0,
    output logic y1,
    output logic y0,
    output logic seg_a,
    output logic seg_b,
    output logic seg_c,
    output logic seg_d,
    output logic seg_e,
    output logic seg_f,
    output logic seg_g
);

    logic [3:0] s;
    mode_e      mode;
    class_e     cls;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] digit;
    logic [6:0] hex_seg;
    logic [6:0] letter;
    logic [6:0] seg_nxt;
    logic [1:0] y_q;
    logic [6:0] seg_q;

    assign s    = {p3, p2, p1, p0};
    assign mode = mode_e'({e1, e0});
    assign cls  = classify(s);

    // s never exceeds 15, so one subtraction is a full mod-10
    always_comb begin
        units = s;
        tens  = 4'd0;
        if (s >= THR_PASS) begin
            units = s - 4'd10;
            tens  = 4'd1;
        end
    end

    always_comb begin
        digit = s;
        unique case (mode)
            MODE_UNITS: digit = units;
            MODE_TENS:  digit = tens;
            default:    digit = s;
        endcase
    end

    hex_to_7seg u_hex (
        .val (digit),
        .seg (hex_seg)
    );

    always_comb begin
        letter = SEG_LF;
        unique case (cls)
            FAIL:    letter = SEG_LF;
            RECOV:   letter = SEG_LR;
            PASS:    letter = SEG_LA;
            EXCEL:   letter = SEG_LE;
            default: letter = SEG_LF;
        endcase
    end

    assign seg_nxt = (mode == MODE_CLASS) ? letter : hex_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= 2'b00;
            seg_q <= 7'd0;
        end else begin
            y_q   <= cls;
            seg_q <= seg_nxt;
        end
    end

    assign {y1, y0} = y_q;
    assign {seg_a, seg_b, seg_c, seg_d,
            seg_e, seg_f, seg_g} = seg_q;

endmodule

// File: tb/tb_principal.sv
// Self-checking bench for principal: directed table,
// exhaustive sweep, random vectors, async reset cases.
module tb_principal;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] e = 2'b00;
    logic [3:0] p = 4'd0;
    logic y1, y0;
    logic seg_a, seg_b, seg_c, seg_d;
    logic seg_e, seg_f, seg_g;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    principal dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e1    (e[1]),
        .e0    (e[0]),
        .p3    (p[3]),
        .p2    (p[2]),
        .p1    (p[1]),
        .p0    (p[0]),
        .y1    (y1),
        .y0    (y0),
        .seg_a (seg_a),
        .seg_b (seg_b),
        .seg_c (seg_c),
        .seg_d (seg_d),
        .seg_e (seg_e),
        .seg_f (seg_f),
        .seg_g (seg_g)
    );

    // Segment list as letters, e.g. "abc" -> {a..g} bits
    function automatic logic [6:0] segs(input string str);
        logic [6:0] r;
        r = 7'd0;
        for (int i = 0; i < str.len(); i++) begin
            int k;
            k = int'(str[i]) - 97;
            r[6 - k] = 1'b1;
        end
        return r;
    endfunction

    function automatic string hex_str(input int d);
        case (d)
            0:  return "abcdef";
            1:  return "bc";
            2:  return "abdeg";
            3:  return "abcdg";
            4:  return "bcfg";
            5:  return "acdfg";
            6:  return "acdefg";
            7:  return "abc";
            8:  return "abcdefg";
            9:  return "abcdfg";
            10: return "abcefg";
            11: return "cdefg";
            12: return "adef";
            13: return "bcdeg";
            14: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    function automatic logic [1:0] model_y(input int s);
        if (s <= 4) return 2'd0;
        if (s <= 9) return 2'd1;
        if (s <= 13) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [6:0] model_seg(
        input int m,
        input int s
    );
        case (m)
            0: return segs(hex_str(s));
            1: begin
                case (model_y(s))
                    2'd0: return segs("aefg");
                    2'd1: return segs("eg");
                    2'd2: return segs("abcefg");
                    default: return segs("adefg");
                endcase
            end
            2: return segs(hex_str(s % 10));
            default: return segs(hex_str(s / 10));
        endcase
    endfunction

    task automatic check(
        input string name,
        input logic [1:0] ey,
        input logic [6:0] eseg
    );
        logic [1:0] ay;
        logic [6:0] aseg;
        ay = {y1, y0};
        aseg = {seg_a, seg_b, seg_c, seg_d,
                seg_e, seg_f, seg_g};
        checks++;
        if (ay !== ey || aseg !== eseg) begin
            errors++;
            $display("FAIL %s: y=%b seg=%b, want y=%b seg=%b",
                     name, ay, aseg, ey, eseg);
        end
    endtask

    // Drive on falling edge, check just after next rise
    task automatic apply(input int m, input int s);
        @(negedge clk);
        e = 2'(m);
        p = 4'(s);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         m;
        int         s;
        logic [1:0] ey;
        logic [6:0] eseg;
        string      name;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt.push_back('{0, 11, 2'b10, segs("cdefg"), "hex_b"});
        vt.push_back('{0, 0, 2'b00, segs("abcdef"), "hex_0"});
        vt.push_back('{0, 4, 2'b00, segs("bcfg"), "thr_4"});
        vt.push_back('{0, 5, 2'b01, segs("acdfg"), "thr_5"});
        vt.push_back('{0, 9, 2'b01, segs("abcdfg"), "thr_9"});
        vt.push_back('{0, 10, 2'b10, segs("abcefg"), "thr_10"});
        vt.push_back('{0, 13, 2'b10, segs("bcdeg"), "thr_13"});
        vt.push_back('{0, 14, 2'b11, segs("adefg"), "thr_14"});
        vt.push_back('{1, 3, 2'b00, segs("aefg"), "let_F"});
        vt.push_back('{1, 7, 2'b01, segs("eg"), "let_r"});
        vt.push_back('{1, 12, 2'b10, segs("abcefg"), "let_A"});
        vt.push_back('{1, 15, 2'b11, segs("adefg"), "let_E"});
        vt.push_back('{2, 15, 2'b11, segs("acdfg"), "units_15"});
        vt.push_back('{3, 15, 2'b11, segs("bc"), "tens_15"});
        vt.push_back('{2, 9, 2'b01, segs("abcdfg"), "units_9"});
        vt.push_back('{3, 9, 2'b01, segs("abcdef"), "tens_9"});

        // reset held with e=11, p=1111
        e = 2'b11;
        p = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 2'b00, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 2'b11, segs("bc"));

        foreach (vt[i]) begin
            apply(vt[i].m, vt[i].s);
            check(vt[i].name, vt[i].ey, vt[i].eseg);
        end

        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 16; s++) begin
                apply(m, s);
                check($sformatf("sweep_m%0d_s%0d", m, s),
                      model_y(s), model_seg(m, s));
            end
        end

        for (int i = 0; i < 200; i++) begin
            int m, s;
            m = int'($urandom_range(3, 0));
            s = int'($urandom_range(15, 0));
            apply(m, s);
            check($sformatf("rand_m%0d_s%0d", m, s),
                  model_y(s), model_seg(m, s));
        end

        // async pulse between edges, s=8 e=00
        apply(0, 8);
        check("pre_pulse", 2'b01, segs("abcdefg"));
        #2;
        rst_n = 1'b0;
        #1;
        check("pulse_blank", 2'b00, 7'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("pulse_hold", 2'b00, 7'd0);
        @(posedge clk);
        #1;
        check("pulse_restore", 2'b01, segs("abcdefg"));

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
